// File: rtl/mem_wb_pkg.sv
// MEM/WB pipeline register: shared types.
// FSM states, entry layout and default widths.
package mem_wb_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    localparam logic [REG_W-1:0] NOP_REG_DEFAULT = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } mem_wb_state_t;

    typedef struct packed {
        logic              wb_en;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] wdata;
    } mem_wb_entry_t;

endpackage

// File: rtl/mem_wb_pipe_if.sv
// MEM/WB stage bundle: upstream beat, write-back beat,
// flush and the forwarding/occupancy taps.
interface mem_wb_pipe_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
);

    logic              in_valid;
    logic              in_ready;
    logic              in_wb_en;
    logic              in_sel_mem;
    logic [DATA_W-1:0] in_memdata;
    logic [DATA_W-1:0] in_alu;
    logic [REG_W-1:0]  in_wreg;
    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic              out_wb_en;
    logic [DATA_W-1:0] out_wdata;
    logic [REG_W-1:0]  out_wreg;
    logic              fwd_hit;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_wb_en, in_sel_mem,
        output in_memdata, in_alu, in_wreg,
        output flush, out_ready,
        input  in_ready, out_valid, out_wb_en,
        input  out_wdata, out_wreg, fwd_hit, occupancy
    );

    modport slave (
        input  in_valid, in_wb_en, in_sel_mem,
        input  in_memdata, in_alu, in_wreg,
        input  flush, out_ready,
        output in_ready, out_valid, out_wb_en,
        output out_wdata, out_wreg, fwd_hit, occupancy
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register with optional skid entry.
// Main entry drives the output; skid absorbs one stalled beat.
module pipe_skid_buf
    import mem_wb_pkg::*;
#(
    parameter int W       = 21,
    parameter bit SKID_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    mem_wb_state_t state;
    logic [W-1:0]  main_q;
    logic [W-1:0]  skid_q;
    logic          rdy_q;
    logic          vld_q;
    logic [1:0]    occ_q;
    logic          accept;
    logic          consume;

    // Skid build keeps in_ready registered; single build
    // lets a consume free the entry in the same cycle.
    assign in_ready  = SKID_EN ? rdy_q : (~vld_q | out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign consume   = vld_q & out_ready;
    assign out_valid = vld_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
            occ_q  <= 2'd0;
        end else if (flush) begin
            state  <= EMPTY;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_data;
                        state  <= ONE;
                        vld_q  <= 1'b1;
                        occ_q  <= 2'd1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_q <= in_data;
                    end else if (accept && SKID_EN) begin
                        skid_q <= in_data;
                        state  <= TWO;
                        rdy_q  <= 1'b0;
                        occ_q  <= 2'd2;
                    end else if (consume) begin
                        state  <= EMPTY;
                        vld_q  <= 1'b0;
                        occ_q  <= 2'd0;
                    end
                end
                TWO: begin
                    if (consume) begin
                        main_q <= skid_q;
                        state  <= ONE;
                        rdy_q  <= 1'b1;
                        occ_q  <= 2'd1;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    rdy_q  <= 1'b1;
                    vld_q  <= 1'b0;
                    occ_q  <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: write-back mux at the input,
// elastic buffer, NOP gating and forwarding tap.
module mem_wb_pipe #(
    parameter int              DATA_W  = 16,
    parameter int              REG_W   = 4,
    parameter logic [REG_W-1:0] NOP_REG = {REG_W{1'b1}},
    parameter bit              SKID_EN = 1'b1
) (
    input logic          clk,
    input logic          rst,
    mem_wb_pipe_if.slave bus
);

    typedef struct packed {
        logic              wb_en;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t in_entry;
    entry_t out_entry;
    logic   held;

    assign in_entry.wb_en = bus.in_wb_en;
    assign in_entry.wreg  = bus.in_wreg;
    assign in_entry.wdata = bus.in_sel_mem ? bus.in_memdata
                                           : bus.in_alu;

    pipe_skid_buf #(
        .W       (ENTRY_W),
        .SKID_EN (SKID_EN)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_entry),
        .out_valid (held),
        .out_ready (bus.out_ready),
        .out_data  (out_entry),
        .occupancy (bus.occupancy)
    );

    // An empty stage must look like a harmless bubble downstream.
    assign bus.out_valid = held;
    assign bus.out_wb_en = held & out_entry.wb_en;
    assign bus.out_wdata = held ? out_entry.wdata : '0;
    assign bus.out_wreg  = held ? out_entry.wreg : NOP_REG;
    assign bus.fwd_hit   = held & out_entry.wb_en
                         & (out_entry.wreg != NOP_REG);

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: skid build (dut0)
// and single-entry build (dut1).
module tb_mem_wb_pipe;

    localparam int             DW  = 16;
    localparam int             RW  = 4;
    localparam logic [RW-1:0]  NOP = 4'hF;

    typedef struct {
        logic          wb_en;
        logic [RW-1:0] wreg;
        logic [DW-1:0] wdata;
        logic          fwd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    always #5 clk = ~clk;

    mem_wb_pipe_if #(.DATA_W(DW), .REG_W(RW)) b0 ();
    mem_wb_pipe_if #(.DATA_W(DW), .REG_W(RW)) b1 ();

    mem_wb_pipe #(
        .DATA_W (DW), .REG_W (RW), .NOP_REG (NOP), .SKID_EN (1'b1)
    ) dut0 (
        .clk (clk), .rst (rst), .bus (b0)
    );

    mem_wb_pipe #(
        .DATA_W (DW), .REG_W (RW), .NOP_REG (NOP), .SKID_EN (1'b0)
    ) dut1 (
        .clk (clk), .rst (rst), .bus (b1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Scoreboard monitors: pop on every consume.
    always @(negedge clk) begin
        if (!rst && b0.out_valid === 1'b1 && b0.out_ready) begin
            if (q0.size() == 0) begin
                total_cnt++;
                $display("FAIL sb0_unexpected: got wreg 0x%0h wdata 0x%0h expected no beat",
                         b0.out_wreg, b0.out_wdata);
            end else begin
                e0 = q0.pop_front();
                chk("sb0_wdata", 32'(b0.out_wdata), 32'(e0.wdata));
                chk("sb0_wreg", 32'(b0.out_wreg), 32'(e0.wreg));
                chk("sb0_wb_en", 32'(b0.out_wb_en), 32'(e0.wb_en));
                chk("sb0_fwd", 32'(b0.fwd_hit), 32'(e0.fwd));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b1.out_valid === 1'b1 && b1.out_ready) begin
            if (q1.size() == 0) begin
                total_cnt++;
                $display("FAIL sb1_unexpected: got wreg 0x%0h wdata 0x%0h expected no beat",
                         b1.out_wreg, b1.out_wdata);
            end else begin
                e1 = q1.pop_front();
                chk("sb1_wdata", 32'(b1.out_wdata), 32'(e1.wdata));
                chk("sb1_wreg", 32'(b1.out_wreg), 32'(e1.wreg));
                chk("sb1_wb_en", 32'(b1.out_wb_en), 32'(e1.wb_en));
            end
        end
    end

    task automatic idle0();
        b0.in_valid = 1'b0; b0.in_wb_en = 1'b0; b0.in_sel_mem = 1'b0;
        b0.in_memdata = '0; b0.in_alu = '0; b0.in_wreg = '0;
        b0.flush = 1'b0;
    endtask

    task automatic idle1();
        b1.in_valid = 1'b0; b1.in_wb_en = 1'b0; b1.in_sel_mem = 1'b0;
        b1.in_memdata = '0; b1.in_alu = '0; b1.in_wreg = '0;
        b1.flush = 1'b0;
    endtask

    task automatic beat0(input logic wb, input logic sel,
                         input logic [DW-1:0] md, input logic [DW-1:0] alu,
                         input logic [RW-1:0] wr, input bit push,
                         input logic [DW-1:0] ew, input logic ef);
        b0.in_valid = 1'b1; b0.in_wb_en = wb; b0.in_sel_mem = sel;
        b0.in_memdata = md; b0.in_alu = alu; b0.in_wreg = wr;
        if (push) q0.push_back('{wb_en: wb, wreg: wr, wdata: ew, fwd: ef});
    endtask

    task automatic beat1(input logic [DW-1:0] alu, input logic [RW-1:0] wr);
        b1.in_valid = 1'b1; b1.in_wb_en = 1'b1; b1.in_sel_mem = 1'b0;
        b1.in_memdata = 16'h0; b1.in_alu = alu; b1.in_wreg = wr;
        q1.push_back('{wb_en: 1'b1, wreg: wr, wdata: alu, fwd: 1'b1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals0(input string nm);
        chk({nm, "_out_valid"}, 32'(b0.out_valid), 32'd0);
        chk({nm, "_in_ready"}, 32'(b0.in_ready), 32'd1);
        chk({nm, "_out_wb_en"}, 32'(b0.out_wb_en), 32'd0);
        chk({nm, "_out_wdata"}, 32'(b0.out_wdata), 32'd0);
        chk({nm, "_out_wreg"}, 32'(b0.out_wreg), 32'hF);
        chk({nm, "_fwd_hit"}, 32'(b0.fwd_hit), 32'd0);
        chk({nm, "_occ"}, 32'(b0.occupancy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200us");
        $fatal(1);
    end

    initial begin
        idle0(); idle1();
        b0.out_ready = 1'b1; b1.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_vals0("rst0");
        chk("rst1_occ", 32'(b1.occupancy), 32'd0);
        chk("rst1_in_ready", 32'(b1.in_ready), 32'd1);
        tick();
        rst = 1'b0;

        // Streaming at full rate.
        for (int i = 0; i < 4; i++) begin
            beat0(1'b1, 1'b0, 16'h0, 16'(16'h11 + i), 4'(i + 1),
                  1'b1, 16'(16'h11 + i), 1'b1);
            @(negedge clk);
            chk("stream_in_ready", 32'(b0.in_ready), 32'd1);
            if (i > 0) chk("stream_occ", 32'(b0.occupancy), 32'd1);
            tick();
        end
        idle0();
        @(negedge clk);
        chk("stream_tail_occ", 32'(b0.occupancy), 32'd1);
        tick();
        @(negedge clk);
        chk("stream_empty_occ", 32'(b0.occupancy), 32'd0);
        chk("stream_empty_wreg", 32'(b0.out_wreg), 32'hF);
        tick();

        // Back-pressure with skid.
        b0.out_ready = 1'b0;
        beat0(1'b1, 1'b0, 16'h0, 16'h0021, 4'd6, 1'b1, 16'h0021, 1'b1);
        @(negedge clk);
        chk("bp_rdy_a", 32'(b0.in_ready), 32'd1);
        tick();
        beat0(1'b1, 1'b0, 16'h0, 16'h0022, 4'd7, 1'b1, 16'h0022, 1'b1);
        @(negedge clk);
        chk("bp_rdy_b", 32'(b0.in_ready), 32'd1);
        chk("bp_occ_b", 32'(b0.occupancy), 32'd1);
        tick();
        beat0(1'b1, 1'b0, 16'h0, 16'h0023, 4'd8, 1'b0, 16'h0023, 1'b1);
        @(negedge clk);
        chk("bp_rdy_c", 32'(b0.in_ready), 32'd0);
        chk("bp_occ_c", 32'(b0.occupancy), 32'd2);
        tick();
        @(negedge clk);
        chk("bp_rdy_hold", 32'(b0.in_ready), 32'd0);
        tick();
        idle0();
        b0.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rdy_drain", 32'(b0.in_ready), 32'd0);
        chk("bp_occ_drain", 32'(b0.occupancy), 32'd2);
        tick();
        @(negedge clk);
        chk("bp_rdy_back", 32'(b0.in_ready), 32'd1);
        chk("bp_occ_back", 32'(b0.occupancy), 32'd1);
        tick();
        @(negedge clk);
        chk("bp_occ_end", 32'(b0.occupancy), 32'd0);
        tick();

        // Memory-data select.
        beat0(1'b1, 1'b1, 16'hBEEF, 16'h1234, 4'd9, 1'b1, 16'hBEEF, 1'b1);
        tick();
        idle0();
        tick();

        // Forwarding tap.
        beat0(1'b1, 1'b0, 16'h0, 16'h0055, 4'd5, 1'b1, 16'h0055, 1'b1);
        tick();
        beat0(1'b1, 1'b0, 16'h0, 16'h0066, 4'hF, 1'b1, 16'h0066, 1'b0);
        tick();
        beat0(1'b0, 1'b0, 16'h0, 16'h0077, 4'd3, 1'b1, 16'h0077, 1'b0);
        tick();
        idle0();
        tick();
        tick();

        // Flush at occupancy 2 with a beat offered.
        b0.out_ready = 1'b0;
        beat0(1'b1, 1'b0, 16'h0, 16'h00A1, 4'd10, 1'b1, 16'h00A1, 1'b1);
        tick();
        beat0(1'b1, 1'b0, 16'h0, 16'h00A2, 4'd11, 1'b1, 16'h00A2, 1'b1);
        tick();
        beat0(1'b1, 1'b0, 16'h0, 16'h00A3, 4'd12, 1'b0, 16'h00A3, 1'b1);
        b0.flush = 1'b1;
        @(negedge clk);
        chk("fl2_occ_pre", 32'(b0.occupancy), 32'd2);
        tick();
        idle0();
        q0.delete();
        @(negedge clk);
        chk("fl2_occ", 32'(b0.occupancy), 32'd0);
        chk("fl2_out_valid", 32'(b0.out_valid), 32'd0);
        chk("fl2_out_wreg", 32'(b0.out_wreg), 32'hF);
        chk("fl2_in_ready", 32'(b0.in_ready), 32'd1);
        b0.out_ready = 1'b1;
        tick();
        tick();

        // Flush at occupancy 1 while consuming and offering.
        beat0(1'b1, 1'b0, 16'h0, 16'h00B1, 4'd13, 1'b1, 16'h00B1, 1'b1);
        tick();
        beat0(1'b1, 1'b0, 16'h0, 16'h00B2, 4'd14, 1'b0, 16'h00B2, 1'b1);
        b0.flush = 1'b1;
        @(negedge clk);
        chk("fl1_in_ready", 32'(b0.in_ready), 32'd1);
        tick();
        idle0();
        q0.delete();
        @(negedge clk);
        chk("fl1_occ", 32'(b0.occupancy), 32'd0);
        chk("fl1_out_valid", 32'(b0.out_valid), 32'd0);
        tick();
        tick();

        // Reset while holding two beats.
        b0.out_ready = 1'b0;
        beat0(1'b1, 1'b0, 16'h0, 16'h00C1, 4'd1, 1'b1, 16'h00C1, 1'b1);
        tick();
        beat0(1'b1, 1'b0, 16'h0, 16'h00C2, 4'd2, 1'b1, 16'h00C2, 1'b1);
        tick();
        idle0();
        @(negedge clk);
        chk("rst2_occ_pre", 32'(b0.occupancy), 32'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q0.delete();
        @(negedge clk);
        reset_vals0("rst2");
        b0.out_ready = 1'b1;
        tick();
        tick();

        // Single-entry build under back-pressure.
        b1.out_ready = 1'b0;
        beat1(16'h0031, 4'd1);
        @(negedge clk);
        chk("se_rdy_a", 32'(b1.in_ready), 32'd1);
        chk("se_occ_a", 32'(b1.occupancy), 32'd0);
        tick();
        beat1(16'h0032, 4'd2);
        @(negedge clk);
        chk("se_rdy_b", 32'(b1.in_ready), 32'd0);
        chk("se_occ_b", 32'(b1.occupancy), 32'd1);
        tick();
        @(negedge clk);
        chk("se_rdy_hold", 32'(b1.in_ready), 32'd0);
        chk("se_occ_hold", 32'(b1.occupancy), 32'd1);
        tick();
        b1.out_ready = 1'b1;
        @(negedge clk);
        chk("se_rdy_comb", 32'(b1.in_ready), 32'd1);
        chk("se_occ_comb", 32'(b1.occupancy), 32'd1);
        tick();
        idle1();
        @(negedge clk);
        chk("se_occ_last", 32'(b1.occupancy), 32'd1);
        tick();
        @(negedge clk);
        chk("se_occ_end", 32'(b1.occupancy), 32'd0);
        tick();

        repeat (3) tick();
        chk("sb0_drained", 32'(q0.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
